// File: rtl/pc_sequencer.sv
// Next-PC sequencer: resolves jumps and branches, owns the architectural PC,
// the RUN/HALTED state and saturating branch-statistics counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  input  logic             in_stall,
  input  logic             in_J,
  input  logic             in_JW,
  input  logic             in_JR,
  input  logic             in_BEQ,
  input  logic             in_BNE,
  input  logic             in_BGEZ,
  input  logic             in_halt,
  input  logic             in_go,
  input  logic [15:0]      in_imm16,
  input  logic [25:0]      in_target26,
  input  logic [31:0]      in_rs_data,
  input  logic [31:0]      in_rt_data,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_link,
  output logic             out_taken,
  output logic             out_redirect,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_cnt_total,
  output logic [CNT_W-1:0] out_cnt_uncond,
  output logic [CNT_W-1:0] out_cnt_cond,
  output logic [CNT_W-1:0] out_cnt_taken
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
  logic [CNT_W-1:0] cnt_uncond_q, cnt_uncond_d;
  logic [CNT_W-1:0] cnt_cond_q, cnt_cond_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic        uncond;
  logic        cond_any;
  logic        br_sel_taken;
  logic        cond_taken;
  logic        taken;
  logic        ret;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  assign pc4       = pc_q + 32'd4;
  assign br_off    = {{14{in_imm16[15]}}, in_imm16, 2'b00};
  assign br_target = pc4 + br_off;
  assign j_target  = {pc4[31:28], in_target26, 2'b00};
  assign jr_target = {in_rs_data[31:2], 2'b00};

  assign uncond   = in_J | in_JW | in_JR;
  assign cond_any = in_BEQ | in_BNE | in_BGEZ;

  // Only the highest-priority branch strobe is evaluated; lower ones are ignored.
  always_comb begin
    br_sel_taken = 1'b0;
    if (in_BEQ) begin
      br_sel_taken = (in_rs_data == in_rt_data);
    end else if (in_BNE) begin
      br_sel_taken = (in_rs_data != in_rt_data);
    end else if (in_BGEZ) begin
      br_sel_taken = ~in_rs_data[31];
    end
  end

  assign cond_taken = ~uncond & br_sel_taken;
  assign taken      = (uncond | br_sel_taken) & in_valid;
  assign ret        = in_valid & ~in_stall & (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (ret && in_halt) state_d = ST_HALTED;
      ST_HALTED: if (in_go)          state_d = ST_RUN;
      default:                       state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    redirect_d   = ret & taken;
    cnt_total_d  = cnt_total_q;
    cnt_uncond_d = cnt_uncond_q;
    cnt_cond_d   = cnt_cond_q;
    cnt_taken_d  = cnt_taken_q;
    if (ret) begin
      // A retiring halt simply falls through; flow change resumes after in_go.
      if (in_halt) begin
        pc_d = pc4;
      end else if (in_JR) begin
        pc_d = jr_target;
      end else if (in_J || in_JW) begin
        pc_d = j_target;
      end else if (br_sel_taken) begin
        pc_d = br_target;
      end else begin
        pc_d = pc4;
      end
      cnt_total_d  = sat_inc(cnt_total_q, 1'b1);
      cnt_uncond_d = sat_inc(cnt_uncond_q, uncond);
      cnt_cond_d   = sat_inc(cnt_cond_q, ~uncond & cond_any);
      cnt_taken_d  = sat_inc(cnt_taken_q, cond_taken);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      redirect_q   <= 1'b0;
      cnt_total_q  <= '0;
      cnt_uncond_q <= '0;
      cnt_cond_q   <= '0;
      cnt_taken_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      cnt_total_q  <= cnt_total_d;
      cnt_uncond_q <= cnt_uncond_d;
      cnt_cond_q   <= cnt_cond_d;
      cnt_taken_q  <= cnt_taken_d;
    end
  end

  assign out_pc         = pc_q;
  assign out_link       = pc4;
  assign out_taken      = taken;
  assign out_redirect   = redirect_q;
  assign out_halted     = (state_q == ST_HALTED);
  assign out_cnt_total  = cnt_total_q;
  assign out_cnt_uncond = cnt_uncond_q;
  assign out_cnt_cond   = cnt_cond_q;
  assign out_cnt_taken  = cnt_taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, checked
// against an architectural model through an expected-response queue.
module tb_pc_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, stall, j, jw, jr, beq, bne, bgez, halt, go;
  logic [15:0] imm16;
  logic [25:0] t26;
  logic [31:0] rs, rt;

  logic [31:0] pc, link;
  logic        taken, redir, halted;
  logic [15:0] c_tot, c_unc, c_cnd, c_tkn;
  logic [31:0] pc_s, link_s;
  logic        taken_s, redir_s, halted_s;
  logic [3:0]  s_tot, s_unc, s_cnd, s_tkn;

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(16)) u_dut (
    .in_clk(clk), .in_rst(rst), .in_valid(valid), .in_stall(stall),
    .in_J(j), .in_JW(jw), .in_JR(jr), .in_BEQ(beq), .in_BNE(bne), .in_BGEZ(bgez),
    .in_halt(halt), .in_go(go), .in_imm16(imm16), .in_target26(t26),
    .in_rs_data(rs), .in_rt_data(rt),
    .out_pc(pc), .out_link(link), .out_taken(taken), .out_redirect(redir),
    .out_halted(halted), .out_cnt_total(c_tot), .out_cnt_uncond(c_unc),
    .out_cnt_cond(c_cnd), .out_cnt_taken(c_tkn)
  );

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(4)) u_dut4 (
    .in_clk(clk), .in_rst(rst), .in_valid(valid), .in_stall(stall),
    .in_J(j), .in_JW(jw), .in_JR(jr), .in_BEQ(beq), .in_BNE(bne), .in_BGEZ(bgez),
    .in_halt(halt), .in_go(go), .in_imm16(imm16), .in_target26(t26),
    .in_rs_data(rs), .in_rt_data(rt),
    .out_pc(pc_s), .out_link(link_s), .out_taken(taken_s), .out_redirect(redir_s),
    .out_halted(halted_s), .out_cnt_total(s_tot), .out_cnt_uncond(s_unc),
    .out_cnt_cond(s_cnd), .out_cnt_taken(s_tkn)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        rst, v, st, j, jw, jr, beq, bne, bgez, halt, go;
    logic [15:0] imm;
    logic [25:0] t26;
    logic [31:0] rs, rt;
  } stim_t;

  typedef struct {
    logic [31:0] pc, link;
    logic        taken, redir, halted;
    int          tot, unc, cnd, tkn;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // architectural model
  bit          m_known = 0;
  logic [31:0] m_pc;
  bit          m_halted, m_redir;
  int          m_tot, m_unc, m_cnd, m_tkn;

  function automatic int sat(input int c, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (c > lim) ? lim : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_known = 1; m_pc = 32'h0; m_halted = 0; m_redir = 0;
    m_tot = 0; m_unc = 0; m_cnd = 0; m_tkn = 0;
  endtask

  // ---------------- driver ----------------
  function automatic stim_t mk();
    stim_t s;
    s = '{default: '0};
    s.v = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t        e;
    logic [31:0] pc4;
    bit          unc, bt, ret;
    int          off;
    @(negedge clk);
    rst = s.rst; valid = s.v; stall = s.st; j = s.j; jw = s.jw; jr = s.jr;
    beq = s.beq; bne = s.bne; bgez = s.bgez; halt = s.halt; go = s.go;
    imm16 = s.imm; t26 = s.t26; rs = s.rs; rt = s.rt;
    pc4 = m_pc + 32'd4;
    unc = s.j | s.jw | s.jr;
    if (s.beq)       bt = (s.rs == s.rt);
    else if (s.bne)  bt = (s.rs != s.rt);
    else if (s.bgez) bt = ($signed(s.rs) >= 0);
    else             bt = 0;
    if (m_known) begin
      e.pc = m_pc; e.link = pc4; e.taken = (unc | bt) & s.v;
      e.redir = m_redir; e.halted = m_halted;
      e.tot = m_tot; e.unc = m_unc; e.cnd = m_cnd; e.tkn = m_tkn;
      exp_q.push_back(e);
    end
    if (s.rst) begin
      model_reset();
    end else if (m_known) begin
      ret = s.v && !s.st && !m_halted;
      m_redir = ret && (unc || bt);
      if (m_halted) begin
        if (s.go) m_halted = 0;
      end else if (ret) begin
        m_tot++;
        if (unc) m_unc++;
        else if (s.beq | s.bne | s.bgez) m_cnd++;
        if (!unc && bt) m_tkn++;
        off = $signed(s.imm);
        if (s.halt)             m_pc = pc4;
        else if (s.jr)          m_pc = {s.rs[31:2], 2'b00};
        else if (s.j || s.jw)   m_pc = {pc4[31:28], s.t26, 2'b00};
        else if (bt)            m_pc = pc4 + 32'(off * 4);
        else                    m_pc = pc4;
        if (s.halt) m_halted = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("link", link, e.link);
      chk("taken", {31'b0, taken}, {31'b0, e.taken});
      chk("redirect", {31'b0, redir}, {31'b0, e.redir});
      chk("halted", {31'b0, halted}, {31'b0, e.halted});
      chk("cnt_total", {16'b0, c_tot}, 32'(sat(e.tot, 16)));
      chk("cnt_uncond", {16'b0, c_unc}, 32'(sat(e.unc, 16)));
      chk("cnt_cond", {16'b0, c_cnd}, 32'(sat(e.cnd, 16)));
      chk("cnt_taken", {16'b0, c_tkn}, 32'(sat(e.tkn, 16)));
      chk("pc_w4", pc_s, e.pc);
      chk("cnt4_total", {28'b0, s_tot}, 32'(sat(e.tot, 4)));
      chk("cnt4_uncond", {28'b0, s_unc}, 32'(sat(e.unc, 4)));
      chk("cnt4_cond", {28'b0, s_cnd}, 32'(sat(e.cnd, 4)));
      chk("cnt4_taken", {28'b0, s_tkn}, 32'(sat(e.tkn, 4)));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    rst = 1; valid = 0; stall = 0; j = 0; jw = 0; jr = 0; beq = 0; bne = 0;
    bgez = 0; halt = 0; go = 0; imm16 = 0; t26 = 0; rs = 0; rt = 0;
    repeat (2) @(posedge clk);
    s = mk(); s.rst = 1; step(s);
    chk("reset_pc", pc, 32'h0);
    chk("reset_halted", {31'b0, halted}, 32'h0);

    // sequential fetch
    for (int i = 0; i < 3; i++) step(mk());
    chk("seq_pc", pc, 32'hC);
    chk("seq_total", {16'b0, c_tot}, 32'd3);
    chk("seq_redirect", {31'b0, redir}, 32'h0);

    // BEQ taken backward, then not taken
    s = mk(); s.jr = 1; s.rs = 32'h100; step(s);
    s = mk(); s.beq = 1; s.rs = 5; s.rt = 5; s.imm = 16'hFFFE; step(s);
    chk("beq_taken_pc", pc, 32'hFC);
    chk("beq_taken_cnt", {16'b0, c_tkn}, 32'd1);
    chk("beq_redirect", {31'b0, redir}, 32'h1);
    s = mk(); s.jr = 1; s.rs = 32'h100; step(s);
    s = mk(); s.beq = 1; s.rs = 5; s.rt = 6; s.imm = 16'hFFFE; step(s);
    chk("beq_nt_pc", pc, 32'h104);
    chk("beq_nt_taken_cnt", {16'b0, c_tkn}, 32'd1);

    // JW region jump, JR alignment
    s = mk(); s.jr = 1; s.rs = 32'h3000_0010; step(s);
    s = mk(); s.jw = 1; s.t26 = 26'h40; step(s);
    chk("jw_pc", pc, 32'h3000_0100);
    s = mk(); s.jr = 1; s.rs = 32'h1237; step(s);
    chk("jr_pc", pc, 32'h1234);

    // BGEZ sign, J over BEQ
    s = mk(); s.bgez = 1; s.rs = 32'h8000_0000; s.imm = 16'h10; step(s);
    chk("bgez_neg_pc", pc, 32'h1238);
    s = mk(); s.bgez = 1; s.rs = 0; s.imm = 16'h10; step(s);
    chk("bgez_zero_pc", pc, 32'h127C);
    s = mk(); s.j = 1; s.beq = 1; s.t26 = 26'h123; s.rs = 1; s.rt = 1; step(s);
    chk("j_beq_pc", pc, 32'h48C);

    // halt / resume / reset while halted
    s = mk(); s.jr = 1; s.rs = 32'h40; step(s);
    s = mk(); s.halt = 1; step(s);
    chk("halt_pc", pc, 32'h44);
    chk("halt_state", {31'b0, halted}, 32'h1);
    for (int i = 0; i < 5; i++) begin s = mk(); s.j = 1; s.t26 = 26'h5; step(s); end
    chk("halted_pc_frozen", pc, 32'h44);
    s = mk(); s.v = 0; s.go = 1; step(s);
    step(mk());
    chk("resume_pc", pc, 32'h48);
    s = mk(); s.halt = 1; step(s);
    s = mk(); s.rst = 1; step(s);
    chk("rst_halted_pc", pc, 32'h0);
    chk("rst_halted_state", {31'b0, halted}, 32'h0);
    chk("rst_halted_total", {16'b0, c_tot}, 32'h0);

    // saturation of the narrow counters, stall with a taken branch
    for (int i = 0; i < 20; i++) step(mk());
    chk("sat4_total", {28'b0, s_tot}, 32'd15);
    chk("wide_total", {16'b0, c_tot}, 32'd20);
    s = mk(); s.st = 1; s.beq = 1; s.rs = 3; s.rt = 3; s.imm = 16'h8; step(s);
    chk("stall_pc", pc, 32'd80);
    chk("stall_redirect", {31'b0, redir}, 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      s = mk();
      s.rst  = ($urandom_range(0, 99) == 0);
      s.v    = ($urandom_range(0, 9) < 8);
      s.st   = ($urandom_range(0, 9) < 2);
      s.j    = ($urandom_range(0, 9) == 0);
      s.jw   = ($urandom_range(0, 9) == 0);
      s.jr   = ($urandom_range(0, 9) == 0);
      s.beq  = ($urandom_range(0, 4) == 0);
      s.bne  = ($urandom_range(0, 4) == 0);
      s.bgez = ($urandom_range(0, 4) == 0);
      s.halt = ($urandom_range(0, 19) == 0) && !(s.j | s.jw | s.jr | s.beq | s.bne | s.bgez);
      s.go   = ($urandom_range(0, 3) == 0);
      s.imm  = 16'($urandom);
      s.t26  = 26'($urandom);
      s.rs   = $urandom;
      s.rt   = ($urandom_range(0, 1) == 0) ? s.rs : $urandom;
      step(s);
    end

    // drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
